// File: rtl/reg_count_down_key_if.sv
// Key/counter bus for reg_count_down_key: key and enable in, step/max config in, count and pulses out.
interface reg_count_down_key_if #(
  parameter int unsigned REG_WD = 4
);
  logic              en_i;
  logic              key_ni;
  logic [REG_WD-1:0] reg_step;
  logic [REG_WD-1:0] reg_max;
  logic [REG_WD-1:0] reg_o;
  logic              step_o;
  logic              wrap_o;

  modport master (
    output en_i, key_ni, reg_step, reg_max,
    input  reg_o, step_o, wrap_o
  );

  modport slave (
    input  en_i, key_ni, reg_step, reg_max,
    output reg_o, step_o, wrap_o
  );
endinterface

// File: rtl/reg_count_down_key.sv
// Debounced pushbutton down counter with wrap to reg_max.
// Optional auto-repeat while the key is held: define AUTOREPEAT_EN.
module reg_count_down_key #(
  parameter int unsigned REG_WD        = 4,
  parameter int unsigned DB_CYCLES     = 500000,
  parameter int unsigned REPEAT_CYCLES = 12500000
) (
  input  logic                 clk_i,
  input  logic                 rstn_max,
  reg_count_down_key_if.slave  bus
);

  localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_e;

  state_e            state_q;
  logic              sync1_q;
  logic              key_s_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [REG_WD-1:0] reg_q;
  logic [REG_WD-1:0] reg_d;
  logic              step_q;
  logic              wrap_q;
  logic              wrap_d;
  logic              db_done;
  logic              ev_d;

`ifdef AUTOREPEAT_EN
  localparam int unsigned REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  logic [REP_W-1:0]  rep_q;
  logic              rep_hit;

  assign rep_hit = (state_q == HELD) && !key_s_q && (rep_q == REP_W'(REPEAT_CYCLES - 1));
`endif

  assign db_done = (cnt_q == CNT_W'(DB_CYCLES - 1));

  always_comb begin
    ev_d = (state_q == PRESS_DB) && !key_s_q && db_done;
`ifdef AUTOREPEAT_EN
    ev_d = ev_d || rep_hit;
`endif
  end

  // Out-of-range recovery takes priority over the zero-step and wrap cases.
  always_comb begin
    reg_d  = reg_q;
    wrap_d = 1'b0;
    if (reg_q > bus.reg_max) begin
      reg_d = bus.reg_max;
    end else if (bus.reg_step == '0) begin
      reg_d = reg_q;
    end else if (reg_q >= bus.reg_step) begin
      reg_d = reg_q - bus.reg_step;
    end else begin
      reg_d  = bus.reg_max;
      wrap_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_max) begin
    if (!rstn_max) begin
      state_q <= IDLE;
      sync1_q <= 1'b1;
      key_s_q <= 1'b1;
      cnt_q   <= '0;
      reg_q   <= '0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
`ifdef AUTOREPEAT_EN
      rep_q   <= '0;
`endif
    end else begin
      sync1_q <= bus.key_ni;
      key_s_q <= sync1_q;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
      if (ev_d && bus.en_i) begin
        reg_q  <= reg_d;
        step_q <= 1'b1;
        wrap_q <= wrap_d;
      end

      case (state_q)
        IDLE: begin
`ifdef AUTOREPEAT_EN
          rep_q <= '0;
`endif
          if (!key_s_q) begin
            state_q <= PRESS_DB;
            cnt_q   <= '0;
          end
        end
        PRESS_DB: begin
          if (key_s_q)      state_q <= IDLE;
          else if (db_done) state_q <= HELD;
          else              cnt_q   <= cnt_q + CNT_W'(1);
        end
        HELD: begin
          if (key_s_q) begin
            state_q <= REL_DB;
            cnt_q   <= '0;
          end
`ifdef AUTOREPEAT_EN
          else if (rep_hit) rep_q <= '0;
          else              rep_q <= rep_q + REP_W'(1);
`endif
        end
        REL_DB: begin
          if (!key_s_q)     state_q <= HELD;
          else if (db_done) state_q <= IDLE;
          else              cnt_q   <= cnt_q + CNT_W'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.reg_o  = reg_q;
  assign bus.step_o = step_q;
  assign bus.wrap_o = wrap_q;

endmodule

// File: tb/tb_reg_count_down_key.sv
// Directed bench for reg_count_down_key (DB_CYCLES=4, REPEAT_CYCLES=8, REG_WD=4).
module tb_reg_count_down_key;

  localparam int unsigned REG_WD = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  reg_count_down_key_if #(.REG_WD(REG_WD)) bus ();

  reg_count_down_key #(
    .REG_WD       (REG_WD),
    .DB_CYCLES    (4),
    .REPEAT_CYCLES(8)
  ) dut (
    .clk_i   (clk),
    .rstn_max(rstn),
    .bus     (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int n_step, n_wrap, first_step, edge_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_meas();
    n_step = 0; n_wrap = 0; first_step = 0; edge_i = 0;
  endtask

  // Count n rising edges, sampling outputs 1 time unit after each.
  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      edge_i++;
      if (bus.step_o === 1'b1) begin
        n_step++;
        if (first_step == 0) first_step = edge_i;
      end
      if (bus.wrap_o === 1'b1) n_wrap++;
    end
  endtask

  task automatic drive(input logic lvl, input int n);
    @(negedge clk);
    bus.key_ni = lvl;
    run(n);
  endtask

  task automatic press(input string tag, input int exp_reg, input int exp_steps, input int exp_wraps);
    clear_meas();
    drive(1'b0, 10);
    drive(1'b1, 10);
    check({tag, "_reg"},  32'(bus.reg_o), exp_reg);
    check({tag, "_step"}, n_step, exp_steps);
    check({tag, "_wrap"}, n_wrap, exp_wraps);
  endtask

  initial begin
    bus.key_ni   = 1'b1;
    bus.en_i     = 1'b1;
    bus.reg_max  = 4'd9;
    bus.reg_step = 4'd3;
    rstn         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_reg",  32'(bus.reg_o), 0);
    check("rst_step", 32'(bus.step_o), 0);
    check("rst_wrap", 32'(bus.wrap_o), 0);
    @(negedge clk) rstn = 1'b1;
    repeat (2) @(posedge clk);

    press("p1", 9, 1, 1);
    check("p1_latency", first_step, 7);
    press("p2", 6, 1, 0);
    press("p3", 3, 1, 0);
    press("p4", 0, 1, 0);
    press("p5", 9, 1, 1);

    clear_meas();
    drive(1'b0, 3);
    drive(1'b1, 1);
    drive(1'b0, 10);
    drive(1'b1, 1);
    drive(1'b0, 2);
    drive(1'b1, 10);
    check("bounce_reg",     32'(bus.reg_o), 6);
    check("bounce_step",    n_step, 1);
    check("bounce_latency", first_step, 11);
    check("bounce_wrap",    n_wrap, 0);

    @(negedge clk) bus.en_i = 1'b0;
    press("en0", 6, 0, 0);
    @(negedge clk) bus.en_i = 1'b1;
    press("en1", 3, 1, 0);
    press("p6", 0, 1, 0);
    press("p7", 9, 1, 1);
    @(negedge clk) bus.reg_step = 4'd2;
    press("p8", 7, 1, 0);
    @(negedge clk) bus.reg_max = 4'd5;
    press("oor", 5, 1, 0);
    @(negedge clk) bus.reg_step = 4'd0;
    press("zstep", 5, 1, 0);
    @(negedge clk) bus.reg_step = 4'd2;
    press("lt_step_a", 3, 1, 0);
    press("lt_step_b", 1, 1, 0);
    press("lt_step_c", 5, 1, 1);

    // Reset asserted while in PRESS_DB, key held through release.
    @(negedge clk) begin bus.reg_step = 4'd3; bus.reg_max = 4'd9; end
    clear_meas();
    drive(1'b0, 4);
    @(negedge clk) rstn = 1'b0;
    #1;
    check("rst_pdb_reg",  32'(bus.reg_o), 0);
    check("rst_pdb_step", 32'(bus.step_o), 0);
    @(negedge clk) rstn = 1'b1;
    clear_meas();
    run(10);
    check("rst_pdb_after_reg",     32'(bus.reg_o), 9);
    check("rst_pdb_after_latency", first_step, 7);
    check("rst_pdb_after_wrap",    n_wrap, 1);

    // Reset asserted while HELD, key still held.
    @(negedge clk) rstn = 1'b0;
    #1;
    check("rst_held_reg",  32'(bus.reg_o), 0);
    check("rst_held_wrap", 32'(bus.wrap_o), 0);
    @(negedge clk) rstn = 1'b1;
    clear_meas();
    run(10);
    drive(1'b1, 10);
    check("rst_held_after_reg",     32'(bus.reg_o), 9);
    check("rst_held_after_step",    n_step, 1);
    check("rst_held_after_latency", first_step, 7);

    // Long hold: 30 cycles after HELD entry.
    clear_meas();
    drive(1'b0, 35);
    drive(1'b1, 10);
`ifdef AUTOREPEAT_EN
    check("hold_step", n_step, 4);
    check("hold_reg",  32'(bus.reg_o), 9);
    check("hold_wrap", n_wrap, 1);
`else
    check("hold_step", n_step, 1);
    check("hold_reg",  32'(bus.reg_o), 6);
    check("hold_wrap", n_wrap, 0);
`endif
    check("hold_first", first_step, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
